// File: rtl/char_plotter.sv
// Text-cell glyph plotter: fetches an 8x8 glyph row by row from a synchronous font ROM
// and streams one pixel per cycle to the VGA adapter. Macro CHAR_PLOTTER_TRANSPARENT_BG_EN skips clear bits.
module char_plotter #(
    parameter logic [7:0] ORIGIN_X  = 8'd0,
    parameter logic [6:0] ORIGIN_Y  = 7'd0,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] col_idx,
    input  logic [2:0] row_idx,
    input  logic [6:0] char_code,
    output logic [9:0] glyph_addr,
    input  logic [7:0] glyph_data,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       finishedCharacter
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, DRAW, DONE} state_t;

    state_t     state, state_next;
    logic [1:0] col_l;
    logic [2:0] row_l;
    logic [6:0] char_l;
    logic [2:0] glyph_row;
    logic [2:0] px;
    logic [7:0] shift;
    logic       draw_next;
    logic [2:0] nxt_px;
    logic       nxt_bit;
    logic       plot_next;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // draw_next/nxt_* describe the pixel that the following DRAW cycle will present
    always_comb begin
        state_next        = state;
        draw_next         = 1'b0;
        nxt_px            = 3'd0;
        nxt_bit           = 1'b0;
        busy              = (state != IDLE);
        finishedCharacter = (state == DONE);
        case (state)
            IDLE:  if (enable) state_next = FETCH;
            FETCH: state_next = LOAD;
            LOAD: begin
                state_next = DRAW;
                draw_next  = 1'b1;
                nxt_bit    = glyph_data[7];
            end
            DRAW: begin
                if (px == 3'd7) begin
                    state_next = (glyph_row == 3'd7) ? DONE : FETCH;
                end else begin
                    draw_next = 1'b1;
                    nxt_px    = px + 3'd1;
                    nxt_bit   = shift[6];
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef CHAR_PLOTTER_TRANSPARENT_BG_EN
    assign plot_next = draw_next & nxt_bit;
`else
    assign plot_next = draw_next;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col_l      <= '0;
            row_l      <= '0;
            char_l     <= '0;
            glyph_row  <= '0;
            px         <= '0;
            shift      <= '0;
            glyph_addr <= '0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (enable) begin
                    col_l      <= col_idx;
                    row_l      <= row_idx;
                    char_l     <= char_code;
                    glyph_row  <= 3'd0;
                    glyph_addr <= {char_code, 3'd0};
                end
                LOAD: begin
                    shift <= glyph_data;
                    px    <= 3'd0;
                end
                DRAW: begin
                    shift <= {shift[6:0], 1'b0};
                    px    <= px + 3'd1;
                    // address for the next row is set up on entry to its FETCH cycle
                    if (px == 3'd7 && glyph_row != 3'd7) begin
                        glyph_row  <= glyph_row + 3'd1;
                        glyph_addr <= {char_l, glyph_row + 3'd1};
                    end
                end
                default: ;
            endcase
            plot <= plot_next;
            if (draw_next) begin
                x      <= ORIGIN_X + {3'b000, col_l, 3'b000} + {5'b00000, nxt_px};
                y      <= ORIGIN_Y + {1'b0, row_l, 3'b000} + {4'b0000, glyph_row};
                colour <= nxt_bit ? FG_COLOUR : BG_COLOUR;
            end
        end
    end

endmodule

// File: tb/tb_char_plotter.sv
// Bench for char_plotter: table vectors, a continuous sequencer run, randomized cells, reset/abort cases.
module tb_char_plotter;

`ifdef CHAR_PLOTTER_TRANSPARENT_BG_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif
    localparam int OX2 = 250;
    localparam int OY2 = 120;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] col_idx = '0;
    logic [2:0] row_idx = '0;
    logic [6:0] char_code = '0;
    logic [9:0] ga, ga_o;
    logic [7:0] gd, gd_o;
    logic [7:0] x, x_o;
    logic [6:0] y, y_o;
    logic [2:0] colour, colour_o;
    logic       plot, plot_o, busy, busy_o, fin, fin_o;

    logic [7:0] rom [0:1023];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fin_cnt = 0;

    char_plotter dut (
        .clock(clock), .resetn(resetn), .enable(enable),
        .col_idx(col_idx), .row_idx(row_idx), .char_code(char_code),
        .glyph_addr(ga), .glyph_data(gd),
        .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .finishedCharacter(fin)
    );

    char_plotter #(.ORIGIN_X(8'd250), .ORIGIN_Y(7'd120)) dut_o (
        .clock(clock), .resetn(resetn), .enable(enable),
        .col_idx(col_idx), .row_idx(row_idx), .char_code(char_code),
        .glyph_addr(ga_o), .glyph_data(gd_o),
        .x(x_o), .y(y_o), .colour(colour_o), .plot(plot_o),
        .busy(busy_o), .finishedCharacter(fin_o)
    );

    always #5 clock = ~clock;

    // synchronous font ROM: data appears the cycle after the address is sampled
    always @(posedge clock) begin
        gd   <= rom[ga];
        gd_o <= rom[ga_o];
        cyc  <= cyc + 1;
        if (fin) fin_cnt <= fin_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge while the DUT is idle. Cycle k after capture: row r = (k-1)/10,
    // phase 0 fetch, 1 load, 2..9 draw pixel phase-2; k=81 is the done cycle.
    task automatic run_char(input logic [1:0] c, input logic [2:0] r, input logic [6:0] ch,
                            input bit keep, output int nplot, output int nfg,
                            output int fx, output int fy, output int fxo, output int fyo);
        int fin0, rr, ph, p, ex, ey, exo, eyo;
        logic [7:0] rowv;
        logic [2:0] r3;
        logic bitv;
        nplot = 0; nfg = 0; fx = -1; fy = -1; fxo = -1; fyo = -1;
        col_idx = c; row_idx = r; char_code = ch; enable = 1'b1;
        check("idle_busy", busy, 0);
        fin0 = fin_cnt;
        for (int k = 1; k <= 81; k++) begin
            @(negedge clock);
            if (k == 1) begin
                enable    = keep;
                col_idx   = 2'($urandom);
                row_idx   = 3'($urandom);
                char_code = 7'($urandom);
            end
            rr = (k == 81) ? 7 : (k - 1) / 10;
            ph = (k - 1) % 10;
            r3 = rr[2:0];
            check("busy", busy, 1);
            check("fin", fin, k == 81);
            check("fin_o", fin_o, k == 81);
            check("glyph_addr", ga, {ch, r3});
            if (k < 81 && ph >= 2) begin
                p    = ph - 2;
                rowv = rom[{ch, r3}];
                bitv = rowv[7 - p];
                ex   = (int'(c) * 8 + p) % 256;
                ey   = (int'(r) * 8 + rr) % 128;
                exo  = (OX2 + int'(c) * 8 + p) % 256;
                eyo  = (OY2 + int'(r) * 8 + rr) % 128;
                check("x", x, ex);
                check("y", y, ey);
                check("colour", colour, bitv ? 3'b111 : 3'b000);
                check("plot", plot, TRANSP ? bitv : 1'b1);
                check("x_origin", x_o, exo);
                check("y_origin", y_o, eyo);
                check("plot_origin", plot_o, TRANSP ? bitv : 1'b1);
                if (plot) nplot++;
                if (colour == 3'b111) nfg++;
                if (k == 3) begin fx = x; fy = y; fxo = x_o; fyo = y_o; end
            end else begin
                check("plot_idle_phase", plot, 0);
                check("plot_o_idle_phase", plot_o, 0);
            end
        end
        @(negedge clock);
        check("back_idle_busy", busy, 0);
        check("back_idle_fin", fin, 0);
        check("fin_once", fin_cnt - fin0, 1);
    endtask

    typedef struct {
        logic [1:0] col;
        logic [2:0] row;
        logic [6:0] ch;
        int x0, y0, x0o, y0o, fg;
    } vec_t;

    initial begin
        vec_t vt[4];
        int np, nf, fx, fy, fxo, fyo, c0, cprev, f0;
        logic [1:0] rc;
        logic [2:0] rr;
        logic [6:0] rch;

        vt[0] = '{2'd2, 3'd5, 7'h41, 16, 40, 10, 32, 2};
        vt[1] = '{2'd0, 3'd0, 7'h12, 0, 0, 250, 120, 16};
        vt[2] = '{2'd3, 3'd7, 7'h7F, 24, 56, 18, 48, 64};
        vt[3] = '{2'd1, 3'd3, 7'h00, 8, 24, 2, 16, 0};

        for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            rom[{7'h41, 3'(i)}] = (i == 0) ? 8'b00011000 : 8'h00;
            rom[{7'h12, 3'(i)}] = 8'b10000001;
            rom[{7'h7F, 3'(i)}] = 8'hFF;
            rom[{7'h00, 3'(i)}] = 8'h00;
        end

        // reset held with enable high: everything quiet
        resetn = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_plot", plot, 0);
            check("rst_busy", busy, 0);
            check("rst_fin", fin, 0);
            check("rst_xyc", {x, y, colour}, 0);
            check("rst_addr", ga, 0);
            check("rst_plot_o", plot_o, 0);
        end
        check("rst_fin_cnt", fin_cnt, 0);
        enable = 1'b0;
        resetn = 1'b1;
        @(negedge clock);
        check("post_rst_busy", busy, 0);

        // table vectors
        for (int i = 0; i < 4; i++) begin
            run_char(vt[i].col, vt[i].row, vt[i].ch, 1'b0, np, nf, fx, fy, fxo, fyo);
            check("tbl_first_x", fx, vt[i].x0);
            check("tbl_first_y", fy, vt[i].y0);
            check("tbl_first_x_origin", fxo, vt[i].x0o);
            check("tbl_first_y_origin", fyo, vt[i].y0o);
            check("tbl_fg_count", nf, vt[i].fg);
            check("tbl_plot_count", np, TRANSP ? vt[i].fg : 64);
            repeat (2) @(negedge clock);
        end

        // continuous run: sequencer walks all 32 cells and wraps back to (0,0)
        for (int i = 0; i < 1024; i += 8) rom[i] = rom[i] | 8'h01;
        f0 = fin_cnt;
        cprev = -1;
        for (int i = 0; i < 33; i++) begin
            c0 = cyc;
            if (cprev >= 0) check("char_spacing", c0 - cprev, 82);
            cprev = c0;
            rc  = 2'(i % 4);
            rr  = 3'((i % 32) / 4);
            rch = 7'($urandom);
            run_char(rc, rr, rch, 1'b1, np, nf, fx, fy, fxo, fyo);
            if (i == 31) begin
                check("last_cell_x0", fx, 24);
                check("last_cell_y0", fy, 56);
            end
            if (i == 32) begin
                check("wrap_x0", fx, 0);
                check("wrap_y0", fy, 0);
            end
        end
        enable = 1'b0;
        check("continuous_fin_total", fin_cnt - f0, 33);
        repeat (2) @(negedge clock);

        // randomized cells with gaps
        for (int i = 0; i < 6; i++) begin
            run_char(2'($urandom), 3'($urandom), 7'($urandom), 1'b0, np, nf, fx, fy, fxo, fyo);
            repeat ($urandom_range(1, 4)) @(negedge clock);
        end

        // abort in the middle of drawing
        col_idx = 2'd1; row_idx = 3'd2; char_code = 7'h7F; enable = 1'b1;
        repeat (30) @(posedge clock);
        #2;
        check("abort_pre_plot", plot, 1);
        check("abort_pre_busy", busy, 1);
        f0 = fin_cnt;
        resetn = 1'b0;
        #1;
        check("abort_plot", plot, 0);
        check("abort_busy", busy, 0);
        check("abort_fin", fin, 0);
        check("abort_addr", ga, 0);
        repeat (3) @(negedge clock);
        check("abort_no_fin", fin_cnt - f0, 0);
        resetn = 1'b1;
        run_char(2'd3, 3'd1, 7'h41, 1'b0, np, nf, fx, fy, fxo, fyo);
        check("abort_restart_y0", fy, 8);
        check("abort_restart_plots", np, TRANSP ? 2 : 64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/char_plotter.md
Name: char_plotter

Overview:
- Consumer end of the text-cell sequencing interface.
- Takes the current cell indices (col_idx/row_idx) and the character code stored at that cell, and reads that character's 8x8 glyph from a synchronous font ROM.
- Emits one pixel write per cycle to the VGA adapter, then pulses finishedCharacter so the cell sequencer advances to the next cell.
- Sits between the cell sequencer/text buffer and the VGA adapter's x/y/colour/plot port.

Parameters:
- ORIGIN_X, 0, x pixel coordinate of cell (0,0) top-left
- ORIGIN_Y, 0, y pixel coordinate of cell (0,0) top-left
- FG_COLOUR, 3'b111, colour for set glyph bits
- BG_COLOUR, 3'b000, colour for clear glyph bits

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  start a character when idle; level-sensitive
- col_idx  in  2  cell column, 0-3
- row_idx  in  3  cell row, 0-7
- char_code  in  7  character at (col_idx,row_idx); must be valid in the capturing IDLE cycle
- glyph_addr  out  10  font ROM address = {char_code_latched, glyph_row}
- glyph_data  in  8  font ROM row data; bit 7 = leftmost pixel; valid 1 cycle after address is sampled
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high in every state except IDLE
- finishedCharacter  out  1  one-cycle pulse when the character is complete

Behaviour:
- One clock; reset is asynchronous and active-low. All registers clear on negedge resetn.
- Reset values: state=IDLE; x, y, colour, plot, busy, finishedCharacter, glyph_addr all 0.
- States:
  - IDLE: if enable, latch col_idx/row_idx/char_code, set glyph_row=0, go to FETCH. Otherwise stay.
  - FETCH (1 cycle): drive glyph_addr; the ROM samples it at the end of this cycle.
  - LOAD (1 cycle): at the end of the cycle, register glyph_data into an 8-bit shift register and set px=0.
  - DRAW (8 cycles, px=0..7): x=ORIGIN_X+col*8+px, y=ORIGIN_Y+row*8+glyph_row. colour=FG_COLOUR if shift[7] else BG_COLOUR. plot=1. Shift left each cycle.
    - After px=7: if glyph_row==7 go to DONE; else increment glyph_row and go to FETCH.
  - DONE (1 cycle): finishedCharacter=1, plot=0, then return to IDLE.
- Output timing: x/y/colour/plot are registered and valid during DRAW cycles only. plot=0 in all other states.
- Timing: 10 cycles per glyph row; 82 cycles from the IDLE capture cycle to the end of DONE.
  - With enable held high, a new character starts every 82 cycles.
  - The sequencer's indices update at the end of DONE, so the next IDLE cycle sees the new cell.
- Arithmetic: coordinate sums wrap modulo the port width (8 bits for x, 7 bits for y). No saturation.
- Input changes: col_idx/row_idx/char_code changes after the capture cycle are ignored until the next IDLE capture.
- enable deasserted mid-character: the character completes normally. enable is only sampled in IDLE.
- Reset mid-character: immediate return to IDLE with reset values. No finishedCharacter pulse.
- glyph_addr holds its last value outside FETCH.

Optional Feature:
- Macro: CHAR_PLOTTER_TRANSPARENT_BG_EN.
- Defined: clear glyph bits produce plot=0 (colour=BG_COLOUR, ignored). Set bits plot FG_COLOUR. Cycle count is unchanged (82).
- Undefined: every DRAW cycle has plot=1, and clear bits are drawn in BG_COLOUR.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with enable=1 -> all outputs 0, busy=0, no plot pulses.
- Single cell: enable=1 for one cycle, col=2, row=5, char=0x41, ROM row0=8'b00011000, other rows 0 -> 64 plot pulses total.
  - First pulse at x=16, y=40. Pulses 4 and 5 (x=19,20) have colour 7; all others colour 0.
  - finishedCharacter is high exactly once, 82 cycles after the capture.
- Continuous run: enable held high with the cell sequencer attached -> 32 finishedCharacter pulses spaced 82 cycles apart. Indices wrap (3,7)->(0,0). Last cell pixels span x=24..31, y=56..63.
- Origin and wrap: ORIGIN_X=250, col=1 -> x values 2..9 (mod 256).
- Transparent build: macro defined, glyph row 8'b10000001 -> per row only px 0 and 7 plot; total 16 plots across 8 rows; finishedCharacter still at cycle 82.
- Abort: assert resetn=0 at DRAW cycle 30 -> plot drops immediately and no finishedCharacter pulse.
  - After release with enable=1, a full 82-cycle character completes from glyph_row 0.
